pc_source_reg: RTL and testbench
================================

# pc_source_reg

Parametrised next-PC selection and PC register for the multicycle datapath. Selects one of NUM_SOURCES candidate addresses (PC+4, ALU result, ALUOut, jump target, exception vector, …) and writes it into the PC under unconditional or branch-conditional write control. Adds stall buffering, so a write requested while the datapath is frozen is held and applied once the stall lifts. Also adds out-of-range selector detection and a previous-PC register for exception return. Sits between the control unit and the instruction-memory address mux.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- NUM_SOURCES, 5, number of candidate next-PC inputs (2..16)
- SEL_WIDTH, 3, selector width; must satisfy 2^SEL_WIDTH ≥ NUM_SOURCES
- RESET_VECTOR, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- selector  in  SEL_WIDTH  index of the source to load (0 = sources[WIDTH-1:0])
- sources  in  NUM_SOURCES*WIDTH  flattened candidate bus; source i = sources[i*WIDTH +: WIDTH]
- pc_write  in  1  unconditional PC write request
- pc_write_cond  in  1  conditional write request, honoured only when branch_taken=1
- branch_taken  in  1  branch condition from ALU/comparator
- stall  in  1  datapath freeze; no PC update while high
- pc_out  out  WIDTH  current PC (registered)
- pc_prev  out  WIDTH  PC value before the most recent update (registered)
- redirect_valid  out  1  one-cycle pulse, high in the first cycle pc_out shows a new value
- pending  out  1  high while a buffered write awaits stall release
- sel_error  out  1  one-cycle pulse after a request with selector ≥ NUM_SOURCES

## Operation
- req = pc_write | (pc_write_cond & branch_taken). A request is valid when selector < NUM_SOURCES.
- Invalid request (selector ≥ NUM_SOURCES):
  - it is dropped; PC, pending buffer and state are unchanged;
  - sel_error = 1 on the next cycle.
- Two-state FSM: IDLE, HOLD.
- IDLE:
  - valid req with stall=0: pc_prev ← pc_out, pc_out ← sources[selector]; stay IDLE.
  - valid req with stall=1: pend_val ← sources[selector]; go to HOLD.
  - no req: hold all registers.
- HOLD:
  - stall=1 with a valid req: pend_val ← new value (latest request wins); stay HOLD.
  - stall=1 with no req: hold.
  - stall=0 with a valid req: the new value is written to pc_out and pend_val is discarded; go to IDLE.
  - stall=0 with no req: pc_out ← pend_val; go to IDLE.
  - In both stall=0 cases, pc_prev ← old pc_out.
  - An invalid req in HOLD raises sel_error and leaves pend_val untouched.
- pending = (state == HOLD).
- Values are passed through unmodified: no arithmetic, no alignment masking.
- Upper selector codes are don't-care only in the sense that they raise sel_error; they never alias to a valid source.
- reset:
  - pc_out = pc_prev = RESET_VECTOR;
  - pend_val = 0;
  - state IDLE;
  - redirect_valid = pending = sel_error = 0.
  - reset overrides all inputs in the same cycle, including mid-HOLD, where the buffered write is lost.

## Timing
- Request to pc_out: 1 cycle. A request sampled at edge N is visible after edge N.
- Buffered request: pc_out updates at the first edge where stall=0.
- redirect_valid is registered. It is high for exactly the one cycle following each pc_out update, including updates where the new value equals the old value.
- sel_error is registered and high for one cycle after the offending edge.
- pending asserts the cycle after the buffering edge and deasserts the cycle after release.
- selector, sources and the write controls are sampled only at the rising edge. No combinational path exists from inputs to outputs.

## Test plan
- Reset then idle: assert reset 2 cycles with all inputs random.
  - Expect pc_out = pc_prev = 0, all flags 0.
  - With no requests for 10 cycles, nothing changes.
- Unconditional write: sources[2] = 0x0000_0040, selector=2, pc_write=1 for 1 cycle.
  - Next cycle: pc_out = 0x40, pc_prev = 0, redirect_valid = 1 for one cycle.
- Conditional write: pc_write_cond=1, selector=1, sources[1] = 0x100.
  - With branch_taken=0: PC unchanged, no redirect.
  - Repeat with branch_taken=1: pc_out = 0x100.
- Stall buffering: stall=1 and write 0x200, then write 0x300 while still stalled.
  - pending = 1 and pc_out unchanged throughout.
  - Drop stall: next cycle pc_out = 0x300, pending = 0, redirect_valid = 1.
  - Separately, release stall with a simultaneous write of 0x400: pc_out = 0x400.
- Selector error: NUM_SOURCES=5, selector=6, pc_write=1.
  - sel_error pulses 1 cycle; pc_out unchanged.
  - Repeat during HOLD: the pending value is retained.
- Reset mid-HOLD: buffer 0x500 under stall, then assert reset.
  - pc_out = RESET_VECTOR, pending = 0.
  - After release, 0x500 never appears.

Source files
------------

// File: rtl/pc_source_reg.sv
// Next-PC source select and PC register, with stall buffering, selector range
// checking and a previous-PC copy for exception return.
module pc_source_reg #(
  parameter int                 WIDTH        = 32,
  parameter int                 NUM_SOURCES  = 5,
  parameter int                 SEL_WIDTH    = 3,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SEL_WIDTH-1:0]         selector,
  input  logic [NUM_SOURCES*WIDTH-1:0] sources,
  input  logic                         pc_write,
  input  logic                         pc_write_cond,
  input  logic                         branch_taken,
  input  logic                         stall,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_prev,
  output logic                         redirect_valid,
  output logic                         pending,
  output logic                         sel_error
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, prev_q, prev_d, pend_q, pend_d;
  logic             redir_q, redir_d, serr_q, serr_d;

  logic [WIDTH-1:0] src_arr [NUM_SOURCES];
  logic [WIDTH-1:0] sel_val;
  logic [31:0]      sel_ext;
  logic             req, sel_ok, vreq;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    assign src_arr[i] = sources[i*WIDTH +: WIDTH];
  end

  assign req     = pc_write | (pc_write_cond & branch_taken);
  assign sel_ext = 32'(selector);
  assign sel_ok  = sel_ext < 32'(NUM_SOURCES);
  assign vreq    = req & sel_ok;

  // Explicit decode so out-of-range codes can never alias onto a real source.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      if (selector == SEL_WIDTH'(i)) sel_val = src_arr[i];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prev_d  = prev_q;
    pend_d  = pend_q;
    redir_d = 1'b0;
    serr_d  = req & ~sel_ok;
    case (state_q)
      IDLE: begin
        if (vreq && !stall) begin
          prev_d  = pc_q;
          pc_d    = sel_val;
          redir_d = 1'b1;
        end else if (vreq && stall) begin
          pend_d  = sel_val;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (vreq) pend_d = sel_val;
        end else begin
          // A fresh request at release supersedes the buffered one.
          prev_d  = pc_q;
          pc_d    = vreq ? sel_val : pend_q;
          redir_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      prev_q  <= RESET_VECTOR;
      pend_q  <= '0;
      redir_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
      serr_q  <= serr_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_prev        = prev_q;
  assign redirect_valid = redir_q;
  assign pending        = (state_q == HOLD);
  assign sel_error      = serr_q;

endmodule

// File: tb/tb_pc_source_reg.sv
// Directed self-checking bench for pc_source_reg (default parameters).
module tb_pc_source_reg;
  localparam int W = 32, NS = 5, SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] selector;
  logic [NS*W-1:0] sources;
  logic          pc_write, pc_write_cond, branch_taken, stall;
  logic [W-1:0]  pc_out, pc_prev;
  logic          redirect_valid, pending, sel_error;

  int checks = 0, passed = 0;

  pc_source_reg #(.WIDTH(W), .NUM_SOURCES(NS), .SEL_WIDTH(SW), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset(reset), .selector(selector), .sources(sources),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
    .stall(stall), .pc_out(pc_out), .pc_prev(pc_prev), .redirect_valid(redirect_valid),
    .pending(pending), .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_src(input int i, input logic [W-1:0] v);
    sources[i*W +: W] = v;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      selector = SW'($urandom); sources = {$urandom, $urandom, $urandom, $urandom, $urandom};
      pc_write = 1'($urandom); pc_write_cond = 1'($urandom);
      branch_taken = 1'($urandom); stall = 1'($urandom);
      step();
    end
    reset = 1'b0; pc_write = 0; pc_write_cond = 0; branch_taken = 0; stall = 0;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_prev", pc_prev, 32'h0);
    chk("reset_flags", {29'b0, redirect_valid, pending, sel_error}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      selector = SW'($urandom); sources = {$urandom, $urandom, $urandom, $urandom, $urandom};
      branch_taken = 1'($urandom);
      step();
      chk("idle_pc", pc_out, 32'h0);
    end
    chk("idle_flags", {29'b0, redirect_valid, pending, sel_error}, 32'h0);
  endtask

  task automatic test_uncond();
    sources = '0; branch_taken = 0;
    set_src(2, 32'h40); selector = 2; pc_write = 1;
    step(); pc_write = 0;
    chk("uncond_pc", pc_out, 32'h40);
    chk("uncond_prev", pc_prev, 32'h0);
    chk("uncond_redir", 32'(redirect_valid), 32'h1);
    step();
    chk("uncond_redir_drop", 32'(redirect_valid), 32'h0);
    chk("uncond_pc_hold", pc_out, 32'h40);
  endtask

  task automatic test_cond();
    set_src(1, 32'h100); selector = 1; pc_write_cond = 1; branch_taken = 0;
    step();
    chk("cond_nt_pc", pc_out, 32'h40);
    chk("cond_nt_redir", 32'(redirect_valid), 32'h0);
    branch_taken = 1;
    step(); pc_write_cond = 0; branch_taken = 0;
    chk("cond_t_pc", pc_out, 32'h100);
    chk("cond_t_prev", pc_prev, 32'h40);
    chk("cond_t_redir", 32'(redirect_valid), 32'h1);
  endtask

  task automatic test_stall();
    stall = 1; set_src(3, 32'h200); selector = 3; pc_write = 1;
    step();
    chk("stall_pend1", 32'(pending), 32'h1);
    chk("stall_pc1", pc_out, 32'h100);
    set_src(3, 32'h300);
    step(); pc_write = 0;
    chk("stall_pend2", 32'(pending), 32'h1);
    chk("stall_pc2", pc_out, 32'h100);
    chk("stall_noredir", 32'(redirect_valid), 32'h0);
    step();
    chk("stall_pc3", pc_out, 32'h100);
    stall = 0;
    step();
    chk("release_pc", pc_out, 32'h300);
    chk("release_prev", pc_prev, 32'h100);
    chk("release_pend", 32'(pending), 32'h0);
    chk("release_redir", 32'(redirect_valid), 32'h1);
    // release coinciding with a fresh write
    stall = 1; set_src(3, 32'h350); pc_write = 1;
    step(); pc_write = 0;
    chk("stall2_pend", 32'(pending), 32'h1);
    stall = 0; set_src(4, 32'h400); selector = 4; pc_write = 1;
    step(); pc_write = 0;
    chk("relwr_pc", pc_out, 32'h400);
    chk("relwr_prev", pc_prev, 32'h300);
    chk("relwr_pend", 32'(pending), 32'h0);
    chk("relwr_redir", 32'(redirect_valid), 32'h1);
  endtask

  task automatic test_sel_error();
    selector = 6; set_src(2, 32'h240); pc_write = 1;
    step(); pc_write = 0;
    chk("serr_pulse", 32'(sel_error), 32'h1);
    chk("serr_pc", pc_out, 32'h400);
    chk("serr_noredir", 32'(redirect_valid), 32'h0);
    step();
    chk("serr_clear", 32'(sel_error), 32'h0);
    selector = 5; pc_write = 1;
    step(); pc_write = 0;
    chk("serr_sel5", 32'(sel_error), 32'h1);
    chk("serr_sel5_pc", pc_out, 32'h400);
    // during HOLD
    stall = 1; selector = 2; pc_write = 1;
    step();
    chk("serr_hold_pend", 32'(pending), 32'h1);
    selector = 7;
    step(); pc_write = 0;
    chk("serr_hold_pulse", 32'(sel_error), 32'h1);
    chk("serr_hold_pend2", 32'(pending), 32'h1);
    stall = 0;
    step();
    chk("serr_hold_keep", pc_out, 32'h240);
    chk("serr_hold_clr", 32'(sel_error), 32'h0);
  endtask

  task automatic test_reset_hold();
    stall = 1; set_src(0, 32'h500); selector = 0; pc_write = 1;
    step(); pc_write = 0;
    chk("rh_pend", 32'(pending), 32'h1);
    reset = 1;
    step(); reset = 0;
    chk("rh_pc", pc_out, 32'h0);
    chk("rh_prev", pc_prev, 32'h0);
    chk("rh_pend_clr", 32'(pending), 32'h0);
    stall = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rh_no500", pc_out, 32'h0);
    end
    chk("rh_noredir", 32'(redirect_valid), 32'h0);
  endtask

  task automatic test_same_value();
    set_src(0, 32'h0); selector = 0; pc_write = 1;
    step(); pc_write = 0;
    chk("same_redir", 32'(redirect_valid), 32'h1);
    chk("same_pc", pc_out, 32'h0);
  endtask

  initial begin
    test_reset();
    test_uncond();
    test_cond();
    test_stall();
    test_sel_error();
    test_reset_hold();
    test_same_value();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
